// File: rtl/game_sequencer.sv
// ============================================================================
//  Module   : game_sequencer
//  Brief    : Whack-a-mole game phase sequencer with scoring, levels and timing.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module game_sequencer #(
    parameter int GAME_SECONDS      = 30,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int OVER_SECONDS      = 5,
    parameter int LEVEL_HITS        = 5,
    parameter int BASE_ON_MS        = 900,
    parameter int STEP_ON_MS        = 100,
    parameter int MIN_ON_MS         = 300,
    parameter int BASE_GAP_MS       = 250,
    parameter int STEP_GAP_MS       = 25,
    parameter int MIN_GAP_MS        = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        start_pulse,
    input  logic        hit_pulse,
    output logic [1:0]  state,
    output logic        game_active,
    output logic [5:0]  sec_left,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        new_high,
    output logic [2:0]  level,
    output logic [9:0]  mole_on_ms,
    output logic [9:0]  gap_ms
);

    localparam logic [1:0]  c_idle       = 2'd0;
    localparam logic [1:0]  c_countdown  = 2'd1;
    localparam logic [1:0]  c_play       = 2'd2;
    localparam logic [1:0]  c_over       = 2'd3;

    localparam logic [5:0]  c_game_sec   = 6'(GAME_SECONDS);
    localparam logic [5:0]  c_cd_sec     = 6'(COUNTDOWN_SECONDS);
    localparam logic [5:0]  c_over_sec   = 6'(OVER_SECONDS);
    localparam logic [7:0]  c_level_hits = 8'(LEVEL_HITS);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [5:0]  r_sec_left;
    logic [15:0] r_score;
    logic [15:0] r_high_score;
    logic        r_new_high;
    logic [2:0]  r_level;
    logic [7:0]  r_hits;
    logic        r_over_first;
    logic [9:0]  r_mole_on_ms;
    logic [9:0]  r_gap_ms;

    logic        w_start;
    logic        w_last_tick;
    logic        w_play_hit;
    logic        w_record;

    // Linear schedule clamped at a floor; the floor test is done before the
    // subtraction so a large level*step can never wrap.
    function automatic logic [9:0] f_sched(input logic [2:0] lvl, input int base,
                                           input int step, input int floor_ms);
        logic [13:0] drop;
        logic [13:0] base_w;
        logic [13:0] floor_w;
        drop    = {11'd0, lvl} * 14'(step);
        base_w  = 14'(base);
        floor_w = 14'(floor_ms);
        if (drop + floor_w >= base_w)
            return 10'(floor_w);
        return 10'(base_w - drop);
    endfunction

    assign w_start     = start_pulse && (r_state == c_idle || r_state == c_over);
    assign w_last_tick = tick_1hz && (r_sec_left == 6'd1);
    assign w_play_hit  = hit_pulse && (r_state == c_play);
    assign w_record    = (r_state == c_over) && r_over_first && (r_score > r_high_score);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_idle;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:      if (w_start)     w_state_nxt = c_countdown;
            c_countdown: if (w_last_tick) w_state_nxt = c_play;
            c_play:      if (w_last_tick) w_state_nxt = c_over;
            c_over: begin
                if (w_start)          w_state_nxt = c_countdown;
                else if (w_last_tick) w_state_nxt = c_idle;
            end
            default:                  w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        state       = r_state;
        game_active = (r_state == c_play);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_left   <= 6'd0;
            r_score      <= 16'd0;
            r_high_score <= 16'd0;
            r_new_high   <= 1'b0;
            r_level      <= 3'd0;
            r_hits       <= 8'd0;
            r_over_first <= 1'b0;
            r_mole_on_ms <= 10'(BASE_ON_MS);
            r_gap_ms     <= 10'(BASE_GAP_MS);
        end else begin
            r_over_first <= (r_state == c_play) && (w_state_nxt == c_over);
            r_mole_on_ms <= f_sched(r_level, BASE_ON_MS, STEP_ON_MS, MIN_ON_MS);
            r_gap_ms     <= f_sched(r_level, BASE_GAP_MS, STEP_GAP_MS, MIN_GAP_MS);

            // Any phase change reloads the timer with the new phase's length.
            if (w_state_nxt != r_state) begin
                case (w_state_nxt)
                    c_countdown: r_sec_left <= c_cd_sec;
                    c_play:      r_sec_left <= c_game_sec;
                    c_over:      r_sec_left <= c_over_sec;
                    default:     r_sec_left <= 6'd0;
                endcase
            end else if (tick_1hz && r_state != c_idle) begin
                r_sec_left <= r_sec_left - 6'd1;
            end

            if (w_start) begin
                r_score <= 16'd0;
                r_level <= 3'd0;
                r_hits  <= 8'd0;
            end else if (w_play_hit) begin
                if (r_score != 16'hFFFF)
                    r_score <= r_score + 16'd1;
                if (r_hits + 8'd1 == c_level_hits) begin
                    r_hits <= 8'd0;
                    if (r_level != 3'd7)
                        r_level <= r_level + 3'd1;
                end else begin
                    r_hits <= r_hits + 8'd1;
                end
            end

            if (w_record)
                r_high_score <= r_score;

            if (w_start || (r_state == c_over && w_state_nxt != c_over))
                r_new_high <= 1'b0;
            else if (w_record)
                r_new_high <= 1'b1;
        end
    end

    assign sec_left   = r_sec_left;
    assign score      = r_score;
    assign high_score = r_high_score;
    assign new_high   = r_new_high;
    assign level      = r_level;
    assign mole_on_ms = r_mole_on_ms;
    assign gap_ms     = r_gap_ms;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
//  Module   : tb_game_sequencer
//  Brief    : Scoreboard bench for game_sequencer with a phase-level model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_game_sequencer;

    localparam int P_GAME  = 4;
    localparam int P_CD    = 2;
    localparam int P_OVER  = 2;
    localparam int P_LH    = 2;

    logic        clk;
    logic        rst;
    logic        tick_1hz;
    logic        start_pulse;
    logic        hit_pulse;
    logic [1:0]  state;
    logic        game_active;
    logic [5:0]  sec_left;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        new_high;
    logic [2:0]  level;
    logic [9:0]  mole_on_ms;
    logic [9:0]  gap_ms;

    game_sequencer #(
        .GAME_SECONDS(P_GAME), .COUNTDOWN_SECONDS(P_CD), .OVER_SECONDS(P_OVER),
        .LEVEL_HITS(P_LH), .BASE_ON_MS(900), .STEP_ON_MS(100), .MIN_ON_MS(300),
        .BASE_GAP_MS(250), .STEP_GAP_MS(25), .MIN_GAP_MS(100)
    ) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start_pulse(start_pulse),
        .hit_pulse(hit_pulse), .state(state), .game_active(game_active),
        .sec_left(sec_left), .score(score), .high_score(high_score),
        .new_high(new_high), .level(level), .mole_on_ms(mole_on_ms), .gap_ms(gap_ms)
    );

    typedef struct {
        int st; int act; int sec; int sc; int hi; int nh; int lv; int on; int gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Phase model: 0 idle, 1 countdown, 2 play, 3 over; timed phases advance
    // to (phase+1)%4 when their seconds run out.
    int phase_len[4] = '{0, P_CD, P_GAME, P_OVER};
    int m_st = 0, m_sec = 0, m_sc = 0, m_hi = 0, m_nh = 0, m_lv = 0, m_hits = 0;
    int m_on = 900, m_gap = 250, m_over_age = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit t, input bit h);
        int o_st, o_sc, o_lv;
        bit starting;
        o_st = m_st; o_sc = m_sc; o_lv = m_lv;
        if (r) begin
            m_st = 0; m_sec = 0; m_sc = 0; m_hi = 0; m_nh = 0; m_lv = 0; m_hits = 0;
            m_on = 900; m_gap = 250; m_over_age = 0;
            return;
        end
        starting = s && (o_st == 0 || o_st == 3);
        if (starting) begin
            m_st = 1; m_sec = P_CD;
        end else if (o_st != 0 && t) begin
            if (m_sec == 1) begin
                m_st  = (o_st + 1) % 4;
                m_sec = phase_len[m_st];
            end else begin
                m_sec = m_sec - 1;
            end
        end
        if (o_st == 2 && h) begin
            if (m_sc < 65535) m_sc = m_sc + 1;
            m_hits = m_hits + 1;
            if (m_hits == P_LH) begin
                m_hits = 0;
                if (m_lv < 7) m_lv = m_lv + 1;
            end
        end
        if (o_st == 3 && m_over_age == 0 && o_sc > m_hi) begin
            m_hi = o_sc;
            m_nh = 1;
        end
        if (o_st == 3 && m_st != 3) m_nh = 0;
        if (starting) begin
            m_sc = 0; m_lv = 0; m_hits = 0; m_nh = 0;
        end
        if (m_st == 3) m_over_age = (o_st == 3) ? m_over_age + 1 : 0;
        m_on  = max2(900 - o_lv * 100, 300);
        m_gap = max2(250 - o_lv * 25, 100);
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after that edge.
    task automatic cycle(input bit r, input bit s, input bit t, input bit h);
        exp_t e;
        @(negedge clk);
        rst = r; start_pulse = s; tick_1hz = t; hit_pulse = h;
        model_step(r, s, t, h);
        e = '{m_st, (m_st == 2) ? 1 : 0, m_sec, m_sc, m_hi, m_nh, m_lv, m_on, m_gap};
        exp_q.push_back(e);
    endtask

    task automatic repeat_cycle(input int n, input bit s, input bit t, input bit h);
        for (int i = 0; i < n; i++) cycle(1'b0, s, t, h);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",       int'(state),       e.st);
                chk("game_active", int'(game_active), e.act);
                chk("sec_left",    int'(sec_left),    e.sec);
                chk("score",       int'(score),       e.sc);
                chk("high_score",  int'(high_score),  e.hi);
                chk("new_high",    int'(new_high),    e.nh);
                chk("level",       int'(level),       e.lv);
                chk("mole_on_ms",  int'(mole_on_ms),  e.on);
                chk("gap_ms",      int'(gap_ms),      e.gap);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; start_pulse = 1'b0; tick_1hz = 1'b0; hit_pulse = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat_cycle(1, 0, 0, 0);
        chk("reset_state", int'(state), 0);
        chk("reset_on",    int'(mole_on_ms), 900);
        chk("reset_gap",   int'(gap_ms), 250);

        // Game 1: five hits, hit in countdown and over ignored.
        repeat_cycle(1, 1, 0, 0);
        repeat_cycle(1, 0, 0, 1);
        repeat_cycle(2, 0, 1, 0);
        repeat_cycle(1, 0, 0, 0);
        chk("g1_play_state", int'(state), 2);
        chk("g1_play_sec",   int'(sec_left), 4);
        chk("g1_active",     int'(game_active), 1);
        chk("g1_cd_hit",     int'(score), 0);
        repeat_cycle(5, 0, 0, 1);
        repeat_cycle(2, 0, 0, 0);
        chk("g1_score", int'(score), 5);
        chk("g1_level", int'(level), 2);
        chk("g1_on",    int'(mole_on_ms), 700);
        chk("g1_gap",   int'(gap_ms), 200);
        repeat_cycle(4, 0, 1, 0);
        repeat_cycle(1, 0, 0, 0);
        repeat_cycle(1, 0, 0, 1);
        repeat_cycle(1, 0, 0, 0);
        chk("g1_over_state", int'(state), 3);
        chk("g1_over_sec",   int'(sec_left), 2);
        chk("g1_high",       int'(high_score), 5);
        chk("g1_new_high",   int'(new_high), 1);
        chk("g1_over_hit",   int'(score), 5);
        repeat_cycle(2, 0, 1, 0);
        repeat_cycle(1, 0, 0, 0);
        chk("g1_idle",    int'(state), 0);
        chk("g1_nh_clr",  int'(new_high), 0);

        // Game 2: three hits, last one on the final play tick.
        repeat_cycle(1, 1, 0, 0);
        repeat_cycle(2, 0, 1, 0);
        repeat_cycle(2, 0, 0, 1);
        repeat_cycle(3, 0, 1, 0);
        repeat_cycle(1, 0, 1, 1);
        repeat_cycle(2, 0, 0, 0);
        chk("g2_state",     int'(state), 3);
        chk("g2_score",     int'(score), 3);
        chk("g2_high",      int'(high_score), 5);
        chk("g2_new_high",  int'(new_high), 0);

        // Restart with start and tick coincident in OVER.
        repeat_cycle(1, 1, 1, 0);
        repeat_cycle(1, 0, 0, 0);
        chk("restart_state", int'(state), 1);
        chk("restart_sec",   int'(sec_left), 2);
        chk("restart_score", int'(score), 0);

        // Reset mid-play.
        repeat_cycle(2, 0, 1, 0);
        repeat_cycle(3, 0, 0, 1);
        repeat_cycle(1, 0, 0, 0);
        chk("pre_rst_score", int'(score), 3);
        chk("pre_rst_high",  int'(high_score), 5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat_cycle(1, 0, 0, 0);
        chk("rst_state", int'(state), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_high",  int'(high_score), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_on",    int'(mole_on_ms), 900);

        // Level saturation with timing clamped to the floors.
        repeat_cycle(1, 1, 0, 0);
        repeat_cycle(2, 0, 1, 0);
        repeat_cycle(20, 0, 0, 1);
        repeat_cycle(2, 0, 0, 0);
        chk("sat_level", int'(level), 7);
        chk("sat_on",    int'(mole_on_ms), 300);
        chk("sat_gap",   int'(gap_ms), 100);
        chk("sat_score", int'(score), 20);

        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(599) == 0), ($urandom_range(15) == 0),
                  ($urandom_range(7) == 0), ($urandom_range(2) == 0));
        repeat_cycle(3, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
